// File: rtl/oscillator_if.sv
// oscillator_if: control and result signals between a voice controller
// (master) and the oscillator (slave).
//   en       - run enable for the phase counter and divider
//   divisor  - note period in clk cycles, 0 = silent
//   quotient - normalised 8-bit phase
//   q_valid  - one-cycle pulse on each quotient update
//   busy     - high while a divide is in flight
interface oscillator_if #(
  parameter int CNT_W = 18
);
  logic             en;
  logic [CNT_W-1:0] divisor;
  logic [7:0]       quotient;
  logic             q_valid;
  logic             busy;

  modport master (
    output en,
    output divisor,
    input  quotient,
    input  q_valid,
    input  busy
  );

  modport slave (
    input  en,
    input  divisor,
    output quotient,
    output q_valid,
    output busy
  );
endinterface

// File: rtl/oscillator.sv
// oscillator: per-voice phase counter plus a multi-cycle restoring divider
// that turns the counter into an 8-bit normalised phase,
// quotient = floor(cnt * 256 / divisor).
// One divide takes 9 edges: a snapshot edge, then 8 edges that each
// retire one quotient bit, MSB first.
// Optional feature macro: OSC_PHASE_RESET_EN adds a phase_rst input that
// clears the counter and aborts any in-flight divide (note-on retrigger).
// Without it, note changes glide from the current counter value.
module oscillator #(
  parameter int CNT_W = 18,
  parameter int Q_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
`ifdef OSC_PHASE_RESET_EN
  input  logic        phase_rst,
`endif
  oscillator_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DIV  = 1'b1
  } state_t;

  // Phase counter
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             cnt_wrap;

  // Divider state
  state_t           state_reg;
  logic [CNT_W:0]   rem_reg;      // partial remainder, one bit wider than cnt
  logic [CNT_W-1:0] div_reg;      // snapshotted divisor
  logic [Q_W-2:0]   q_acc_reg;    // quotient bits retired so far
  logic [2:0]       bit_cnt_reg;  // which quotient bit this DIV edge produces
  logic [Q_W-1:0]   quotient_reg;
  logic             q_valid_reg;
  logic             busy_reg;

  // One restoring-division step, computed from the current partial remainder
  logic [CNT_W+1:0] rem_shift;
  logic [CNT_W+1:0] rem_sub;
  logic             q_bit;
  logic [CNT_W:0]   rem_next;

  // Phase-reset request; tied low when the retrigger feature is absent so
  // the sequential blocks stay identical in both builds.
  logic             phase_clr;

`ifdef OSC_PHASE_RESET_EN
  assign phase_clr = phase_rst;
`else
  assign phase_clr = 1'b0;
`endif

  // Counter next value: wraps when cnt+1 reaches the period, including the
  // case where a freshly lowered divisor is already below the counter.
  always_comb begin
    cnt_wrap = ({1'b0, cnt_reg} + {{CNT_W{1'b0}}, 1'b1}) >= {1'b0, bus.divisor};
    cnt_next = cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    if (bus.divisor == '0 || cnt_wrap) begin
      cnt_next = '0;
    end
  end

  // Phase counter: advances on every enabled edge, holds while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (phase_clr) begin
      cnt_reg <= '0;
    end else if (bus.en) begin
      cnt_reg <= cnt_next;
    end
  end

  // Restoring step: shift the remainder left and subtract the divisor if it
  // fits. A zero divisor never subtracts, so the quotient comes out 0.
  always_comb begin
    rem_shift = {rem_reg, 1'b0};
    rem_sub   = rem_shift - {2'b00, div_reg};
    q_bit     = (div_reg != '0) && (rem_shift >= {2'b00, div_reg});
    rem_next  = q_bit ? rem_sub[CNT_W:0] : rem_shift[CNT_W:0];
  end

  // Divider FSM: snapshot in IDLE, eight bit edges in DIV, then deliver.
  // Outputs are registered here so busy/q_valid are glitch-free.
  always_ff @(posedge clk) begin
    if (rst || phase_clr) begin
      state_reg    <= IDLE;
      rem_reg      <= '0;
      div_reg      <= '0;
      q_acc_reg    <= '0;
      bit_cnt_reg  <= '0;
      quotient_reg <= '0;
      q_valid_reg  <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      q_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.en) begin
            rem_reg     <= {1'b0, cnt_reg};
            div_reg     <= bus.divisor;
            q_acc_reg   <= '0;
            bit_cnt_reg <= '0;
            busy_reg    <= 1'b1;
            state_reg   <= DIV;
          end
        end
        DIV: begin
          // en is deliberately ignored here: a started divide always finishes.
          rem_reg     <= rem_next;
          q_acc_reg   <= {q_acc_reg[Q_W-3:0], q_bit};
          bit_cnt_reg <= bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            quotient_reg <= {q_acc_reg, q_bit};
            q_valid_reg  <= 1'b1;
            busy_reg     <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.quotient = quotient_reg;
  assign bus.q_valid  = q_valid_reg;
  assign bus.busy     = busy_reg;

endmodule

// File: tb/tb_oscillator.sv
// tb_oscillator: directed steps followed by randomized stimulus, checked
// every cycle against a transaction-level reference model
// (quotient = floor(c*256/d) delivered 9 edges after the snapshot).
// Define OSC_PHASE_RESET_EN for both bench and design to cover retrigger.
module tb_oscillator;
  localparam int CNT_W = 18;

  logic clk = 1'b0;
  logic rst;
`ifdef OSC_PHASE_RESET_EN
  logic phase_rst;
`endif

  oscillator_if #(.CNT_W(CNT_W)) bus ();

  oscillator #(.CNT_W(CNT_W), .Q_W(8)) dut (
    .clk      (clk),
`ifdef OSC_PHASE_RESET_EN
    .phase_rst(phase_rst),
`endif
    .rst      (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  int     m_cnt;
  int     m_c;
  int     m_d;
  int     m_edges;    // edges elapsed since snapshot
  bit     m_busy;
  bit     m_qv;
  int     m_q;
  int     total;
  int     bad;
  int     nv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge using the inputs the DUT saw at that edge.
  function automatic void model_edge(input bit r, input bit pr, input bit en, input int div);
    int old_cnt;
    old_cnt = m_cnt;
    if (r || pr) begin
      m_cnt = 0; m_busy = 0; m_q = 0; m_qv = 0; m_edges = 0;
      return;
    end
    m_qv = 0;
    if (m_busy) begin
      m_edges++;
      if (m_edges == 8) begin
        longint num;
        num   = longint'(m_c) * 256;
        m_q   = (m_d == 0) ? 0 : int'((num / m_d) % 256);
        m_qv  = 1;
        m_busy = 0;
      end
    end else if (en) begin
      m_c = old_cnt; m_d = div; m_busy = 1; m_edges = 0;
    end
    if (en) begin
      if (div == 0 || old_cnt >= div - 1) m_cnt = 0;
      else m_cnt = old_cnt + 1;
    end
  endfunction

  task automatic tick();
    bit pr;
    pr = 0;
`ifdef OSC_PHASE_RESET_EN
    pr = phase_rst;
`endif
    @(posedge clk);
    model_edge(rst, pr, bus.en, int'(bus.divisor));
    #1;
    check("quotient", 32'(bus.quotient), 32'(m_q));
    check("q_valid", 32'(bus.q_valid), 32'(m_qv));
    check("busy", 32'(bus.busy), 32'(m_busy));
  endtask

  task automatic do_reset(input int div);
    rst = 1'b1; bus.en = 1'b1; bus.divisor = CNT_W'(div);
    tick(); tick();
    rst = 1'b0;
  endtask

  function automatic int pick_div();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 0;
    if (r < 3) return m_cnt + 1 + $urandom_range(0, 600);
    return m_cnt + 1 + $urandom_range(0, 30);
  endfunction

  initial begin
    total = 0; bad = 0;
    m_cnt = 0; m_c = 0; m_d = 0; m_edges = 0; m_busy = 0; m_qv = 0; m_q = 0;
    rst = 1'b1; bus.en = 1'b1; bus.divisor = CNT_W'(512);
`ifdef OSC_PHASE_RESET_EN
    phase_rst = 1'b0;
`endif

    // Reset with en high and a live divisor
    do_reset(512);
    check("rst_quotient", 32'(bus.quotient), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);

    // Mid-range phases on a 512-cycle period
    for (int i = 0; i < 60; i++) tick();

    // Period 10: second divide snapshots cnt=9 -> 230
    do_reset(10);
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.q_valid) begin
        nv++;
        if (nv == 2) check("div10_q", 32'(bus.quotient), 32'd230);
      end
    end
    check("div10_pulses", 32'(nv), 32'd2);

    // Silent note: one zero result every 9 cycles
    do_reset(0);
    nv = 0;
    for (int i = 0; i < 27; i++) begin
      tick();
      if (bus.q_valid) nv++;
    end
    check("silent_pulses", 32'(nv), 32'd3);

    // en dropped at DIV edge 3: result still delivered, then nothing
    do_reset(512);
    for (int i = 0; i < 9 * 20; i++) tick();
    tick(); tick(); tick();
    bus.en = 1'b0;
    nv = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.q_valid) nv++;
    end
    check("en_drop_pulses", 32'(nv), 32'd1);
    bus.en = 1'b1;
    for (int i = 0; i < 20; i++) tick();

    // Reset at DIV edge 4 aborts the divide
    do_reset(300);
    for (int i = 0; i < 9 * 7; i++) tick();
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    check("abort_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) tick();

`ifdef OSC_PHASE_RESET_EN
    // Retrigger pulse mid-divide behaves like reset for the datapath
    for (int i = 0; i < 4; i++) tick();
    phase_rst = 1'b1;
    tick();
    check("retrig_busy", 32'(bus.busy), 32'd0);
    phase_rst = 1'b0;
    for (int i = 0; i < 12; i++) tick();
`endif

    // Randomized: note changes, en gaps, occasional resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) bus.divisor = CNT_W'(pick_div());
      bus.en = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 199) == 0);
`ifdef OSC_PHASE_RESET_EN
      phase_rst = ($urandom_range(0, 149) == 0);
`endif
      tick();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
